writeback_cycle: RTL
====================

Name: writeback_cycle

Overview:
- Final pipeline stage of the 5-stage SimpleRISC core; consumes the MEM-WB register outputs (`*_RW` signals).
- Selects the writeback value, computes the destination register and owns the 16x32 architectural register file.
- Provides two combinational read ports to the operand-fetch stage and a forwarding tap for the hazard/forwarding logic.
- Keeps a retired-instruction counter for debug and performance.

Parameters:
- DATA_W, 32, datapath width
- NREGS, 16, number of architectural registers
- AW, 4, register address width
- RA_IDX, 15, return-address register written by call
- SP_IDX, 14, stack-pointer register
- SP_INIT, 32'h0000_0FFC, reset value of SP_IDX
- PC_INC, 4, byte increment added to pc for the call link value

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- pc_RW  in  32  pc of the instruction in WB
- alu_result_RW  in  32  ALU result
- ldresult_RW  in  32  load data
- RD_RW  in  4  destination field
- isWb_RW  in  1  instruction writes a register
- isLd_RW  in  1  select load data
- isCall_RW  in  1  select pc+PC_INC, destination RA_IDX
- valid_RW  in  1  WB slot holds a real instruction (0 = bubble)
- rd_addr1  in  4  read port 1 address (from OF)
- rd_addr2  in  4  read port 2 address (from OF)
- rd_data1  out  32  read port 1 data
- rd_data2  out  32  read port 2 data
- wb_data  out  32  selected writeback value (forwarding tap)
- wb_dest  out  4  selected destination
- wb_en  out  1  write occurs this cycle
- retired_cnt  out  32  count of retired instructions

Behaviour:
- Reset (rst=0, async):
  - all registers cleared to 0, except reg[SP_IDX]=SP_INIT;
  - retired_cnt=0.
  - wb_en forced 0 while rst=0. wb_data/wb_dest are combinational from inputs and are not reset.
- Result select (combinational, priority order):
  - isCall_RW: pc_RW+PC_INC, truncated mod 2^32;
  - else isLd_RW: ldresult_RW;
  - else alu_result_RW.
- Destination (combinational): RA_IDX if isCall_RW, else RD_RW.
- Write enable: wb_en = rst & valid_RW & isWb_RW. RD_RW may be X when wb_en=0; it must not reach register state.
- Register write:
  - on posedge clk with wb_en=1, reg[wb_dest] <= wb_data;
  - visible at rd_data* from the following cycle (without bypass).
  - One write per cycle. All 16 registers are writable, including r0.
- Read ports: combinational, rd_dataN = reg[rd_addrN], plus bypass (see Optional Feature). Both ports may address the same register.
- retired_cnt:
  - increments by 1 on each posedge clk with rst=1 and valid_RW=1, regardless of isWb_RW (stores and branches count).
  - Wraps 0xFFFF_FFFF -> 0 with no flag.
- Reset mid-operation: an in-flight write in the reset cycle is discarded. The first write after rst deasserts takes effect on the first posedge at which rst=1.
- Latency: writeback value and destination are available in the same cycle (0-cycle); the architectural update takes 1 clock.
- Reset asserting while clk is high has no glitch effect; asynchronous priority over the clock.

Optional Feature:
- Macro WB_RF_BYPASS_EN.
- Defined: when wb_en=1 and rd_addrN==wb_dest, rd_dataN = wb_data in the same cycle (write-through). Operand fetch can then read a value being written this cycle without a stall.
- Undefined: rd_dataN returns the old register contents until the next cycle. The hazard unit must stall or forward to cover the WB->OF distance.

Test Plan:
- Reset check: drive rst=0 with random inputs, then release. Required: rd_addr1=14 -> 0x0000_0FFC; rd_addr2=3 -> 0; retired_cnt=0; wb_en=0.
- ALU writeback:
  - valid=1, isWb=1, RD=5, alu_result=0x1234_5678, one clock.
  - Required: reg5=0x1234_5678, retired_cnt=1.
  - Same with valid=0: reg5 unchanged, count unchanged.
- Load vs call priority:
  - isLd=1, ldresult=0xDEAD_BEEF, RD=2 -> reg2=0xDEAD_BEEF.
  - isCall=1, isLd=1, pc=0x0000_0100, RD=2 -> reg15=0x0000_0104, reg2 unchanged.
- Bypass: rd_addr1=7, write reg7=0xA5A5_A5A5 in the same cycle.
  - With WB_RF_BYPASS_EN: rd_data1=0xA5A5_A5A5 before the edge.
  - Without it: old value before the edge, new value after.
- Store/X destination: valid=1, isWb=0, RD=4'bx.
  - Required: no register changes (compare all 16) and retired_cnt increments.
- Counter wrap and mid-reset:
  - Preload retired_cnt via 2^32-1 retires (or force), one more retire -> 0.
  - Assert rst during a write to reg9 -> reg9=0 after release.

Source files
------------

// File: rtl/writeback_cycle.sv
// Writeback stage: result/destination select, 16x32 register file with two read ports,
// retired-instruction counter. Define WB_RF_BYPASS_EN for same-cycle write-through reads.
module writeback_cycle #(
    parameter int              DATA_W  = 32,
    parameter int              NREGS   = 16,
    parameter int              AW      = 4,
    parameter int              RA_IDX  = 15,
    parameter int              SP_IDX  = 14,
    parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_0FFC,
    parameter int              PC_INC  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_RW,
    input  logic [DATA_W-1:0] alu_result_RW,
    input  logic [DATA_W-1:0] ldresult_RW,
    input  logic [AW-1:0]     RD_RW,
    input  logic              isWb_RW,
    input  logic              isLd_RW,
    input  logic              isCall_RW,
    input  logic              valid_RW,
    input  logic [AW-1:0]     rd_addr1,
    input  logic [AW-1:0]     rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] wb_data,
    output logic [AW-1:0]     wb_dest,
    output logic              wb_en,
    output logic [DATA_W-1:0] retired_cnt
);

    logic [DATA_W-1:0] rf [NREGS];
    logic [DATA_W-1:0] cnt_q;

    always_comb begin
        wb_data = alu_result_RW;
        if (isCall_RW)
            wb_data = pc_RW + DATA_W'(PC_INC);
        else if (isLd_RW)
            wb_data = ldresult_RW;
    end

    assign wb_dest = isCall_RW ? AW'(RA_IDX) : RD_RW;
    // rst gates the enable so nothing is written while reset is held
    assign wb_en   = rst & valid_RW & isWb_RW;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= (i == SP_IDX) ? SP_INIT : '0;
        end else if (wb_en) begin
            rf[wb_dest] <= wb_data;
        end
    end

`ifdef WB_RF_BYPASS_EN
    always_comb begin
        rd_data1 = (wb_en && rd_addr1 == wb_dest) ? wb_data : rf[rd_addr1];
        rd_data2 = (wb_en && rd_addr2 == wb_dest) ? wb_data : rf[rd_addr2];
    end
`else
    always_comb begin
        rd_data1 = rf[rd_addr1];
        rd_data2 = rf[rd_addr2];
    end
`endif

    // Every real instruction retires, whether or not it writes a register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else if (valid_RW)
            cnt_q <= cnt_q + 1'b1;
    end

    assign retired_cnt = cnt_q;

endmodule
